// File: rtl/wishbone_bus_if_pkg.sv
// wishbone_bus_if_pkg: state codes and stall constants shared by the Wishbone bridge
package wishbone_bus_if_pkg;
  localparam logic [1:0] WB_IDLE           = 2'd0;
  localparam logic [1:0] WB_BUSY           = 2'd1;
  localparam logic [1:0] WB_WAIT_FOR_STALL = 2'd2;
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;
endpackage

// File: rtl/wishbone_bus_if.sv
// wishbone_bus_if: bridges one OpenMIPS memory port to a Wishbone B3 classic master bus
module wishbone_bus_if
  import wishbone_bus_if_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int STALL_W = 6,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                stallreq_o,
  output logic                bus_err_o,
  input  logic [DATA_W-1:0]   wishbone_data_i,
  input  logic                wishbone_ack_i,
  output logic [ADDR_W-1:0]   wishbone_addr_o,
  output logic [DATA_W-1:0]   wishbone_data_o,
  output logic                wishbone_we_o,
  output logic [DATA_W/8-1:0] wishbone_sel_o,
  output logic                wishbone_stb_o,
  output logic                wishbone_cyc_o
);
  localparam int CNT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rd_buf;
  logic              in_busy;
  logic              tout;
  assign in_busy   = state == WB_BUSY;
  assign tout      = in_busy && !flush_i && !wishbone_ack_i && TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1);
  assign bus_err_o = tout;
  // core-side view: stall until the cycle resolves, pass ack data through in the same cycle
  always_comb begin
    stallreq_o = state == WB_IDLE ? (cpu_ce_i && !flush_i ? STOP : NO_STOP)
               : in_busy ? (flush_i || wishbone_ack_i || tout ? NO_STOP : STOP)
               : NO_STOP;
    cpu_data_o = state == WB_WAIT_FOR_STALL ? rd_buf
               : in_busy && wishbone_ack_i && !flush_i ? wishbone_data_i
               : '0;
  end
  // bus cycle sequencing; flush beats ack, ack beats timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= WB_IDLE;
      cnt             <= '0;
      rd_buf          <= '0;
      wishbone_addr_o <= '0;
      wishbone_data_o <= '0;
      wishbone_we_o   <= 1'b0;
      wishbone_sel_o  <= '0;
      wishbone_stb_o  <= 1'b0;
      wishbone_cyc_o  <= 1'b0;
    end else if (state == WB_IDLE) begin
      if (cpu_ce_i && !flush_i) begin
        wishbone_addr_o <= cpu_addr_i;
        wishbone_data_o <= cpu_data_i;
        wishbone_we_o   <= cpu_we_i;
        wishbone_sel_o  <= cpu_sel_i;
        wishbone_stb_o  <= 1'b1;
        wishbone_cyc_o  <= 1'b1;
        cnt             <= '0;
        state           <= WB_BUSY;
      end
    end else if (in_busy) begin
      if (flush_i || wishbone_ack_i) begin
        wishbone_addr_o <= '0;
        wishbone_data_o <= '0;
        wishbone_we_o   <= 1'b0;
        wishbone_sel_o  <= '0;
        wishbone_stb_o  <= 1'b0;
        wishbone_cyc_o  <= 1'b0;
        rd_buf          <= flush_i ? rd_buf : wishbone_data_i;
        state           <= !flush_i && stall_i != '0 ? WB_WAIT_FOR_STALL : WB_IDLE;
      end else if (tout) begin
        wishbone_stb_o <= 1'b0;
        wishbone_cyc_o <= 1'b0;
        rd_buf         <= '0;
        state          <= WB_IDLE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (flush_i || stall_i == '0) begin
      state <= WB_IDLE;
    end
  end
endmodule

// File: tb/tb_wishbone_bus_if.sv
// tb_wishbone_bus_if: random and directed checks of the Wishbone bridge against a transaction-level model
module tb_wishbone_bus_if;
  localparam int TMO = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0, ce = 1'b0, we = 1'b0, ack = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata = '0;
  logic [3:0]  sel = '0;
  logic [31:0] cpu_data, wb_addr, wb_data;
  logic        stallreq, bus_err, wb_we, wb_stb, wb_cyc;
  logic [3:0]  wb_sel;
  int total = 0, bad = 0;
  // model: an outstanding transaction record plus the buffered read word
  logic        m_busy = 0, m_wait = 0, m_we = 0, m_stb = 0, m_cyc = 0;
  int          m_age = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdbuf = 0;
  logic [3:0]  m_sel = 0;
  logic        s_stall, s_err, s_stb;
  logic [31:0] s_data;
  always #5 clk = ~clk;
  wishbone_bus_if #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .cpu_ce_i(ce), .cpu_we_i(we),
    .cpu_addr_i(addr), .cpu_sel_i(sel), .cpu_data_i(wdata), .cpu_data_o(cpu_data),
    .stallreq_o(stallreq), .bus_err_o(bus_err), .wishbone_data_i(rdata), .wishbone_ack_i(ack),
    .wishbone_addr_o(wb_addr), .wishbone_data_o(wb_data), .wishbone_we_o(wb_we),
    .wishbone_sel_o(wb_sel), .wishbone_stb_o(wb_stb), .wishbone_cyc_o(wb_cyc)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_we = 0; m_stb = 0; m_cyc = 0; m_age = 0;
    m_addr = 0; m_wdata = 0; m_rdbuf = 0; m_sel = 0;
  endtask
  task automatic compare();
    logic done, to, e_stall;
    logic [31:0] e_data;
    done    = m_busy && !flush && ack;
    to      = m_busy && !flush && !ack && m_age == TMO - 1;
    e_stall = m_busy ? !(flush || ack || to) : m_wait ? 1'b0 : (ce && !flush);
    e_data  = done ? rdata : m_wait ? m_rdbuf : 32'h0;
    chk("stallreq", {31'b0, stallreq}, {31'b0, e_stall});
    chk("cpu_data", cpu_data, e_data);
    chk("bus_err", {31'b0, bus_err}, {31'b0, to});
    chk("wb_addr", wb_addr, m_addr);
    chk("wb_data", wb_data, m_wdata);
    chk("wb_we", {31'b0, wb_we}, {31'b0, m_we});
    chk("wb_sel", {28'b0, wb_sel}, {28'b0, m_sel});
    chk("wb_stb", {31'b0, wb_stb}, {31'b0, m_stb});
    chk("wb_cyc", {31'b0, wb_cyc}, {31'b0, m_cyc});
  endtask
  task automatic model_edge();
    if (m_busy) begin
      if (flush || ack) begin
        m_addr = 0; m_wdata = 0; m_we = 0; m_sel = 0; m_stb = 0; m_cyc = 0; m_busy = 0;
        if (!flush) begin
          m_rdbuf = rdata;
          m_wait  = stall != 0;
        end
      end else if (m_age == TMO - 1) begin
        m_stb = 0; m_cyc = 0; m_rdbuf = 0; m_busy = 0;
      end else m_age++;
    end else if (m_wait) begin
      if (stall == 0 || flush) m_wait = 0;
    end else if (ce && !flush) begin
      m_addr = addr; m_wdata = wdata; m_we = we; m_sel = sel;
      m_stb = 1; m_cyc = 1; m_busy = 1; m_age = 0;
    end
  endtask
  task automatic step(input logic c, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic f, input logic k, input logic [5:0] st,
                      input logic [31:0] r);
    @(negedge clk);
    ce = c; we = w; addr = a; sel = s; wdata = d; flush = f; ack = k; stall = st; rdata = r;
    #3;
    compare();
    s_stall = stallreq; s_data = cpu_data; s_err = bus_err; s_stb = wb_stb;
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic read_req(input logic [31:0] a);
    step(1, 0, a, 4'hf, 0, 0, 0, 0, 0);
  endtask
  initial begin
    #2;
    chk("rst_stb", {31'b0, wb_stb}, 0);
    chk("rst_cyc", {31'b0, wb_cyc}, 0);
    chk("rst_addr", wb_addr, 0);
    chk("rst_stallreq", {31'b0, stallreq}, 0);
    chk("rst_data", cpu_data, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    // 1: read acked on third BUSY cycle
    read_req(32'h100);
    chk("t1_stall0", {31'b0, s_stall}, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_stall1", {31'b0, s_stall}, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_stall2", {31'b0, s_stall}, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
    chk("t1_stall3", {31'b0, s_stall}, 0);
    chk("t1_data", s_data, 32'hDEADBEEF);
    chk("t1_stb_low", {31'b0, wb_stb}, 0);
    chk("t1_cyc_low", {31'b0, wb_cyc}, 0);
    // 2: write presented on the bus
    step(1, 1, 32'h20000004, 4'b0011, 32'h1234, 0, 0, 0, 0);
    chk("t2_addr", wb_addr, 32'h20000004);
    chk("t2_data", wb_data, 32'h1234);
    chk("t2_sel", {28'b0, wb_sel}, 32'h3);
    chk("t2_we", {31'b0, wb_we}, 1);
    chk("t2_stb", {31'b0, wb_stb}, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // 3: ack while the pipeline is stalled
    read_req(32'h200);
    step(0, 0, 0, 0, 0, 0, 1, 6'b000011, 32'hCAFEF00D);
    chk("t3_ack_data", s_data, 32'hCAFEF00D);
    step(1, 0, 32'h300, 4'hf, 0, 0, 0, 6'b000011, 0);
    chk("t3_hold_data", s_data, 32'hCAFEF00D);
    chk("t3_hold_stall", {31'b0, s_stall}, 0);
    chk("t3_no_stb", {31'b0, wb_stb}, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_last_data", s_data, 32'hCAFEF00D);
    idle_step();
    chk("t3_idle_data", s_data, 0);
    // 4: flush coincident with ack
    read_req(32'h400);
    step(0, 0, 0, 0, 0, 1, 1, 0, 32'h55555555);
    chk("t4_data", s_data, 0);
    chk("t4_stall", {31'b0, s_stall}, 0);
    chk("t4_stb", {31'b0, wb_stb}, 0);
    chk("t4_addr", wb_addr, 0);
    idle_step();
    chk("t4_idle_stall", {31'b0, s_stall}, 0);
    // 5: no ack, timeout after four BUSY cycles
    read_req(32'h500);
    for (int i = 0; i < 3; i++) begin
      idle_step();
      chk("t5_no_err", {31'b0, s_err}, 0);
    end
    idle_step();
    chk("t5_err", {31'b0, s_err}, 1);
    chk("t5_stall", {31'b0, s_stall}, 0);
    chk("t5_stb", {31'b0, wb_stb}, 0);
    idle_step();
    chk("t5_err_gone", {31'b0, s_err}, 0);
    // 6: asynchronous reset mid-BUSY, then back-to-back reads
    read_req(32'h600);
    idle_step();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_stb", {31'b0, wb_stb}, 0);
    chk("t6_cyc", {31'b0, wb_cyc}, 0);
    chk("t6_addr", wb_addr, 0);
    chk("t6_stall", {31'b0, stallreq}, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    read_req(32'h700);
    chk("t6_stb_a", {31'b0, wb_stb}, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 32'h1111);
    chk("t6_gap", {31'b0, wb_stb}, 0);
    read_req(32'h704);
    chk("t6_gap_cmp", {31'b0, s_stb}, 0);
    chk("t6_stb_b", {31'b0, wb_stb}, 1);
    chk("t6_addr_b", wb_addr, 32'h704);
    step(0, 0, 0, 0, 0, 0, 1, 0, 32'h2222);
    chk("t6_data_b", s_data, 32'h2222);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic k;
      int mode;
      mode = (i / 300) % 3;
      k = m_busy ? ($urandom_range(0, mode == 0 ? 1 : mode == 1 ? 3 : 9) == 0)
                 : ($urandom_range(0, 15) == 0);
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, 4'($urandom),
           $urandom, $urandom_range(0, 15) == 0, k,
           $urandom_range(0, 3) == 0 ? 6'($urandom) : 6'b0, $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
